// File: rtl/mem_pkg.sv
// Shared encodings and helpers for the data-memory access path.
// Also used by the future cache refill path through load_formatter.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MAX_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } stateT;

  // The reserved size encoding 2'b11 behaves as a word, so any size[1] needs word alignment.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLow);
    return (size == SZ_HALF && addrLow[0]) || (size[1] && addrLow != 2'b00);
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: picks the addressed byte/half lane
// of a 32-bit RAM word and sign- or zero-extends it to 32 bits.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] rdata_raw,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        isSigned,
  output logic [31:0] rdata
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  always_comb begin
    byteVal = 8'(rdata_raw >> {lane, 3'b000});
    halfVal = lane[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    case (size)
      SZ_BYTE: rdata = {{24{isSigned & byteVal[7]}}, byteVal};
      SZ_HALF: rdata = {{16{isSigned & halfVal[15]}}, halfVal};
      default: rdata = rdata_raw;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: byte/half/word stores with lane
// enables, loads with LATENCY-cycle RAM read, stall until the data returns.
module dmem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          stall,
  output logic [31:0]   rdata,
  output logic          rdata_valid,
  output logic          misalign,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(MAX_LATENCY + 1);

  stateT         state, nextState;
  logic [CW-1:0] count;
  logic [1:0]    laneQ, sizeQ;
  logic          signedQ;
  logic [31:0]   fmtData;
  logic          reqMisalign, idleReq, accept, acceptLoad;
  logic          unusedAddr;

  // Upper address bits beyond the RAM depth are ignored so accesses wrap.
  assign unusedAddr = ^req_addr[31:AW+2];

  always_comb begin
    reqMisalign = isMisaligned(req_size, req_addr[1:0]);
    idleReq     = (state == IDLE) && req_valid && !rst;
    accept      = idleReq && !reqMisalign;
    acceptLoad  = accept && !req_write;
  end

  load_formatter u_fmt (
    .rdata_raw(mem_rdata),
    .lane     (laneQ),
    .size     (sizeQ),
    .isSigned (signedQ),
    .rdata    (fmtData)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      laneQ   <= '0;
      sizeQ   <= '0;
      signedQ <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= nextState;
      if (acceptLoad) begin
        count   <= CW'(LATENCY);
        laneQ   <= req_addr[1:0];
        sizeQ   <= req_size;
        signedQ <= req_signed;
      end else if (state == WAIT) begin
        count <= count - 1'b1;
      end
      if (state == WAIT && count == CW'(1)) rdata <= fmtData;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (acceptLoad) nextState = WAIT;
      WAIT:    if (count == CW'(1)) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    stall       = acceptLoad || (state == WAIT);
    rdata_valid = (state == DONE);
    misalign    = idleReq && reqMisalign;
    mem_en      = 1'b0;
    mem_we      = 4'b0000;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (accept) begin
      mem_en   = 1'b1;
      mem_addr = req_addr[AW+1:2];
      if (req_write) begin
        case (req_size)
          SZ_BYTE: begin
            mem_we    = 4'b0001 << req_addr[1:0];
            mem_wdata = {4{req_wdata[7:0]}};
          end
          SZ_HALF: begin
            mem_we    = req_addr[1] ? 4'b1100 : 4'b0011;
            mem_wdata = {2{req_wdata[15:0]}};
          end
          default: begin
            mem_we    = 4'b1111;
            mem_wdata = req_wdata;
          end
        endcase
      end
    end
  end

endmodule
